rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer for the out-of-order RISC-V core, and the writer side of the register-file commit and rename interface. It allocates one entry per decoded instruction and returns that entry's tag as the rename dependency. It collects results from the common data bus (CDB) and retires entries strictly in program order, driving the register-file commit port (valid, rd, value, tag). On a mispredicted branch it raises the pipeline-wide flush.

## Interface
Parameters:
- ROB_SIZE_WIDTH, 3, tag width; entries = 2^ROB_SIZE_WIDTH-1 (tag all-ones reserved as "no dependency")
- REG_NUM_WIDTH, 5, architectural register index width

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global stall; low = hold state
- dec_valid  in  1  issue request
- dec_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=reserved (treated as REG)
- dec_rd  in  REG_NUM_WIDTH  destination register (0 = none)
- dec_pred_taken  in  1  predicted branch direction
- dec_pc_alt  in  32  recovery PC if prediction wrong
- full_out  out  1  no free entry; issue ignored
- tail_out  out  ROB_SIZE_WIDTH  tag the next issue receives
- cdb_valid  in  1  result broadcast
- cdb_tag  in  ROB_SIZE_WIDTH  producing entry
- cdb_value  in  32  result / link value
- cdb_taken  in  1  actual branch direction
- commit_valid_out  out  1  register commit pulse
- commit_rd_out  out  REG_NUM_WIDTH  committed rd
- commit_value_out  out  32  committed value
- commit_tag_out  out  ROB_SIZE_WIDTH  committed entry tag
- store_commit_out  out  1  store may retire to memory
- store_tag_out  out  ROB_SIZE_WIDTH  tag of committing store
- need_flush_out  out  1  mispredict flush pulse
- flush_pc_out  out  32  redirect PC
- q1_tag_in, q2_tag_in  in  ROB_SIZE_WIDTH  operand lookup tags
- q1_ready_out, q2_ready_out  out  1  lookup hit
- q1_value_out, q2_value_out  out  32  lookup value

## Operation
- Circular buffer with head, tail and count (ROB_SIZE_WIDTH bits each). Pointers wrap from 2^W-2 to 0 and never hold the all-ones value.
- Per-entry state: busy, ready, type, rd, value, pred_taken, taken, pc_alt.
- Issue: when dec_valid is high and full_out is low, write the tail entry with busy=1 and ready=0 (STORE: ready=1), then advance tail.
- full_out = (count == 2^W-1). It is computed from registered count and does not account for a commit in the same cycle.
- Writeback: when cdb_valid is high and entry[cdb_tag] is busy, set ready=1 and capture value and taken. Writeback to a non-busy entry is ignored.
- Commit: at most one entry per cycle, only when the head entry is both busy and ready. Commit clears busy and advances head.
  - REG, or BRANCH with correct prediction: commit_valid_out=1 with rd/value/tag. rd=0 is still pulsed; the register file discards it.
  - STORE: store_commit_out=1 and store_tag_out=head.
  - BRANCH with taken != pred_taken: commit_valid_out as above, plus need_flush_out=1 and flush_pc_out=pc_alt. In the same edge all busy bits are cleared, head=tail=0 and count=0.
- While need_flush_out is high, dec_valid and cdb_valid are ignored.
- Count update: an issue and a commit in the same cycle leave count unchanged.
- rdy_in low: no entry, pointer or count change. All pulse outputs (commit_valid_out, store_commit_out, need_flush_out) are cleared to 0.
- Reset: head=tail=count=0, all busy=0, all outputs 0. Reset mid-operation discards every entry immediately (asynchronous).

## Timing
- Issue at edge N: entry allocated; tail_out shows the next tag from cycle N+1.
- CDB write at edge N: earliest commit of that entry at edge N+1, so its outputs are visible in cycle N+1.
- A CDB write to the head in the same cycle as its issue is impossible, because the tag is unallocated until issue completes.
- Commit, store and flush outputs are registered and high for exactly one cycle per retired entry.
- The flush pulse lasts one cycle. Issue may resume in the following cycle.
- Lookup outputs are combinational.

## Configuration
- ROB_FORWARD_EN defined: lookups are live.
  - qN_ready_out=1 when entry[qN_tag_in] is busy and ready, with qN_value_out=entry value.
  - Also qN_ready_out=1 when cdb_valid is high and cdb_tag==qN_tag_in, with qN_value_out=cdb_value (CDB takes priority).
  - Tag all-ones always misses.
- ROB_FORWARD_EN undefined: ports remain; all qN outputs are tied to 0 and no lookup logic is built.

## Test plan
- Reset, then issue REG rd=5 and CDB tag 0 value 0x1234 -> one cycle later: commit_valid_out=1, rd=5, value=0x1234, tag=0.
- Issue 7 entries with W=3 -> full_out=1 and tail_out=0 after wrap. An 8th dec_valid is ignored and count stays 7.
- Issue A, B; CDB writes B first, then A -> commits occur A then B on consecutive cycles, never B first.
- BRANCH pred=0, CDB taken=1, pc_alt=0x80 with 3 younger entries -> need_flush_out=1 and flush_pc_out=0x80 for one cycle. Afterwards count=0, tail_out=0 and the younger entries never commit.
- STORE at head with rdy_in low for 3 cycles -> no store_commit_out while stalled; exactly one pulse after rdy_in returns high.
- With ROB_FORWARD_EN: q1_tag_in=2 while CDB broadcasts tag 2 value 0xBEEF -> q1_ready_out=1, q1_value_out=0xBEEF in the same cycle. Without the macro -> both outputs 0.

Source files
------------

// File: rtl/rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit
// Purpose  : Reorder buffer for the out-of-order RISC-V core. Allocates one
//            entry per decoded instruction, collects CDB results, retires
//            strictly in program order through the register-file commit port,
//            signals store retirement, and raises the pipeline flush on a
//            mispredicted branch.
// Ports    : clk_in / rst_in (async, active-low) / rdy_in (global stall)
//            dec_*      : issue request, full_out / tail_out back to decode
//            cdb_*      : result broadcast (tag, value, branch direction)
//            commit_*   : registered register-file commit pulse
//            store_*    : registered store-retire pulse
//            need_flush_out / flush_pc_out : registered mispredict redirect
//            qN_*       : combinational operand lookup (live only when the
//                         ROB_FORWARD_EN macro is defined, otherwise tied 0)
// Config   : `define ROB_FORWARD_EN enables the operand lookup logic.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_NUM_WIDTH  = 5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      dec_valid,
    input  logic [1:0]                dec_type,
    input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic                      dec_pred_taken,
    input  logic [31:0]               dec_pc_alt,
    output logic                      full_out,
    output logic [ROB_SIZE_WIDTH-1:0] tail_out,
    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic                      cdb_taken,
    output logic                      commit_valid_out,
    output logic [REG_NUM_WIDTH-1:0]  commit_rd_out,
    output logic [31:0]               commit_value_out,
    output logic [ROB_SIZE_WIDTH-1:0] commit_tag_out,
    output logic                      store_commit_out,
    output logic [ROB_SIZE_WIDTH-1:0] store_tag_out,
    output logic                      need_flush_out,
    output logic [31:0]               flush_pc_out,
    input  logic [ROB_SIZE_WIDTH-1:0] q1_tag_in,
    input  logic [ROB_SIZE_WIDTH-1:0] q2_tag_in,
    output logic                      q1_ready_out,
    output logic                      q2_ready_out,
    output logic [31:0]               q1_value_out,
    output logic [31:0]               q2_value_out
);

    // The all-ones tag means "no dependency", so only 2^W-1 entries exist.
    localparam int                        c_ENTRIES  = (1 << ROB_SIZE_WIDTH) - 1;
    localparam logic [ROB_SIZE_WIDTH-1:0] c_TAG_NONE = '1;
    localparam logic [ROB_SIZE_WIDTH-1:0] c_ONE      = ROB_SIZE_WIDTH'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] c_LAST_TAG = c_TAG_NONE - c_ONE;

    localparam logic [1:0] c_TYPE_REG    = 2'd0;
    localparam logic [1:0] c_TYPE_STORE  = 2'd1;
    localparam logic [1:0] c_TYPE_BRANCH = 2'd2;
    localparam logic [1:0] c_TYPE_RSVD   = 2'd3;

    // ---------------------------------------------------------------- state
    logic [c_ENTRIES-1:0]      busy_q, busy_d;
    logic [c_ENTRIES-1:0]      ready_q, ready_d;
    logic [c_ENTRIES-1:0]      pred_q, pred_d;
    logic [c_ENTRIES-1:0]      taken_q, taken_d;
    logic [1:0]                type_q   [c_ENTRIES];
    logic [1:0]                type_d   [c_ENTRIES];
    logic [REG_NUM_WIDTH-1:0]  rd_q     [c_ENTRIES];
    logic [REG_NUM_WIDTH-1:0]  rd_d     [c_ENTRIES];
    logic [31:0]               value_q  [c_ENTRIES];
    logic [31:0]               value_d  [c_ENTRIES];
    logic [31:0]               pc_alt_q [c_ENTRIES];
    logic [31:0]               pc_alt_d [c_ENTRIES];

    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
    logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_SIZE_WIDTH-1:0] count_q, count_d;

    logic                      commit_valid_q, commit_valid_d;
    logic [REG_NUM_WIDTH-1:0]  commit_rd_q, commit_rd_d;
    logic [31:0]               commit_value_q, commit_value_d;
    logic [ROB_SIZE_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic                      store_commit_q, store_commit_d;
    logic [ROB_SIZE_WIDTH-1:0] store_tag_q, store_tag_d;
    logic                      need_flush_q, need_flush_d;
    logic [31:0]               flush_pc_q, flush_pc_d;

    logic w_full;
    logic w_issue;
    logic w_wb;
    logic w_commit;
    logic w_mispredict;

    function automatic logic [ROB_SIZE_WIDTH-1:0] ptr_next(input logic [ROB_SIZE_WIDTH-1:0] p);
        return (p == c_LAST_TAG) ? '0 : p + c_ONE;
    endfunction

    // Full is taken from the registered count only; a same-cycle commit does
    // not free a slot for a same-cycle issue.
    assign w_full = (count_q == c_TAG_NONE);

    // ---------------------------------------------------- next-state logic
    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        pred_d         = pred_q;
        taken_d        = taken_q;
        type_d         = type_q;
        rd_d           = rd_q;
        value_d        = value_q;
        pc_alt_d       = pc_alt_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_tag_d   = commit_tag_q;
        store_commit_d = 1'b0;
        store_tag_d    = store_tag_q;
        need_flush_d   = 1'b0;
        flush_pc_d     = flush_pc_q;
        w_issue        = 1'b0;
        w_wb           = 1'b0;
        w_commit       = 1'b0;
        w_mispredict   = 1'b0;

        if (rdy_in) begin
            // The cycle the flush pulse is visible, decode and CDB traffic
            // still belongs to the squashed path.
            w_issue  = dec_valid && !w_full && !need_flush_q;
            w_wb     = cdb_valid && !need_flush_q && (cdb_tag != c_TAG_NONE)
                       && busy_q[cdb_tag];
            w_commit = busy_q[head_q] && ready_q[head_q];

            if (w_wb) begin
                ready_d[cdb_tag] = 1'b1;
                value_d[cdb_tag] = cdb_value;
                taken_d[cdb_tag] = cdb_taken;
            end

            if (w_issue) begin
                busy_d[tail_q]   = 1'b1;
                // Stores carry nothing back on the CDB, so they are born ready.
                ready_d[tail_q]  = (dec_type == c_TYPE_STORE);
                type_d[tail_q]   = (dec_type == c_TYPE_RSVD) ? c_TYPE_REG : dec_type;
                rd_d[tail_q]     = dec_rd;
                value_d[tail_q]  = '0;
                pred_d[tail_q]   = dec_pred_taken;
                taken_d[tail_q]  = 1'b0;
                pc_alt_d[tail_q] = dec_pc_alt;
                tail_d           = ptr_next(tail_q);
            end

            if (w_commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = ptr_next(head_q);
                if (type_q[head_q] == c_TYPE_STORE) begin
                    store_commit_d = 1'b1;
                    store_tag_d    = head_q;
                end else begin
                    commit_valid_d = 1'b1;
                    commit_rd_d    = rd_q[head_q];
                    commit_value_d = value_q[head_q];
                    commit_tag_d   = head_q;
                    w_mispredict   = (type_q[head_q] == c_TYPE_BRANCH)
                                     && (taken_q[head_q] != pred_q[head_q]);
                end
            end

            case ({w_issue, w_commit})
                2'b10:   count_d = count_q + c_ONE;
                2'b01:   count_d = count_q - c_ONE;
                default: count_d = count_q;
            endcase

            // A mispredict squashes every younger entry, including one
            // being issued on this same edge.
            if (w_mispredict) begin
                busy_d       = '0;
                head_d       = '0;
                tail_d       = '0;
                count_d      = '0;
                need_flush_d = 1'b1;
                flush_pc_d   = pc_alt_q[head_q];
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            pred_q         <= '0;
            taken_q        <= '0;
            for (int i = 0; i < c_ENTRIES; i++) begin
                type_q[i]   <= '0;
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                pc_alt_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            store_commit_q <= 1'b0;
            store_tag_q    <= '0;
            need_flush_q   <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            pred_q         <= pred_d;
            taken_q        <= taken_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            pc_alt_q       <= pc_alt_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_tag_q   <= commit_tag_d;
            store_commit_q <= store_commit_d;
            store_tag_q    <= store_tag_d;
            need_flush_q   <= need_flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    assign full_out         = w_full;
    assign tail_out         = tail_q;
    assign commit_valid_out = commit_valid_q;
    assign commit_rd_out    = commit_rd_q;
    assign commit_value_out = commit_value_q;
    assign commit_tag_out   = commit_tag_q;
    assign store_commit_out = store_commit_q;
    assign store_tag_out    = store_tag_q;
    assign need_flush_out   = need_flush_q;
    assign flush_pc_out     = flush_pc_q;

    // ------------------------------------------------------ operand lookup
`ifdef ROB_FORWARD_EN
    // The CDB result is newer than anything stored, so it wins the lookup.
    always_comb begin
        q1_ready_out = 1'b0;
        q1_value_out = '0;
        if (q1_tag_in != c_TAG_NONE) begin
            if (cdb_valid && (cdb_tag == q1_tag_in)) begin
                q1_ready_out = 1'b1;
                q1_value_out = cdb_value;
            end else if (busy_q[q1_tag_in] && ready_q[q1_tag_in]) begin
                q1_ready_out = 1'b1;
                q1_value_out = value_q[q1_tag_in];
            end
        end
    end

    always_comb begin
        q2_ready_out = 1'b0;
        q2_value_out = '0;
        if (q2_tag_in != c_TAG_NONE) begin
            if (cdb_valid && (cdb_tag == q2_tag_in)) begin
                q2_ready_out = 1'b1;
                q2_value_out = cdb_value;
            end else if (busy_q[q2_tag_in] && ready_q[q2_tag_in]) begin
                q2_ready_out = 1'b1;
                q2_value_out = value_q[q2_tag_in];
            end
        end
    end
`else
    logic w_lookup_unused;
    assign w_lookup_unused = ^{q1_tag_in, q2_tag_in};
    assign q1_ready_out    = 1'b0;
    assign q1_value_out    = '0;
    assign q2_ready_out    = 1'b0;
    assign q2_value_out    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit
// Purpose  : Self-checking bench for rob_commit. A program-order queue model
//            predicts every registered output each cycle; directed literal
//            expectations pin the headline scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_commit;

    localparam int W  = 3;
    localparam int RW = 5;
    localparam int N  = 7;

`ifdef ROB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          dec_valid = 1'b0;
    logic [1:0]    dec_type = 2'd0;
    logic [RW-1:0] dec_rd = '0;
    logic          dec_pred_taken = 1'b0;
    logic [31:0]   dec_pc_alt = '0;
    logic          full_out;
    logic [W-1:0]  tail_out;
    logic          cdb_valid = 1'b0;
    logic [W-1:0]  cdb_tag = '0;
    logic [31:0]   cdb_value = '0;
    logic          cdb_taken = 1'b0;
    logic          commit_valid_out;
    logic [RW-1:0] commit_rd_out;
    logic [31:0]   commit_value_out;
    logic [W-1:0]  commit_tag_out;
    logic          store_commit_out;
    logic [W-1:0]  store_tag_out;
    logic          need_flush_out;
    logic [31:0]   flush_pc_out;
    logic [W-1:0]  q1_tag_in = 3'd0;
    logic [W-1:0]  q2_tag_in = 3'd1;
    logic          q1_ready_out, q2_ready_out;
    logic [31:0]   q1_value_out, q2_value_out;

    always #5 clk_in = ~clk_in;

    rob_commit #(.ROB_SIZE_WIDTH(W), .REG_NUM_WIDTH(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
        .dec_pred_taken(dec_pred_taken), .dec_pc_alt(dec_pc_alt),
        .full_out(full_out), .tail_out(tail_out),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken),
        .commit_valid_out(commit_valid_out), .commit_rd_out(commit_rd_out),
        .commit_value_out(commit_value_out), .commit_tag_out(commit_tag_out),
        .store_commit_out(store_commit_out), .store_tag_out(store_tag_out),
        .need_flush_out(need_flush_out), .flush_pc_out(flush_pc_out),
        .q1_tag_in(q1_tag_in), .q2_tag_in(q2_tag_in),
        .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
        .q1_value_out(q1_value_out), .q2_value_out(q2_value_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------- model
    typedef struct {
        logic [W-1:0]  tag;
        logic [1:0]    kind;
        logic [RW-1:0] rd;
        logic [31:0]   value;
        logic          pred;
        logic          taken;
        logic [31:0]   pc_alt;
        logic          ready;
    } ent_t;

    ent_t          rob[$];       // live entries, oldest first
    logic [W-1:0]  m_tail = '0;
    logic          m_cv = 1'b0, m_sc = 1'b0, m_nf = 1'b0;
    logic [RW-1:0] m_rd = '0;
    logic [31:0]   m_val = '0, m_fpc = '0;
    logic [W-1:0]  m_ctag = '0, m_stag = '0;

    function automatic void mlook(input logic [W-1:0] tag, output logic rdy, output logic [31:0] val);
        rdy = 1'b0;
        val = '0;
        if (FWD && tag != 3'b111) begin
            if (cdb_valid && cdb_tag == tag) begin
                rdy = 1'b1;
                val = cdb_value;
            end else begin
                foreach (rob[i])
                    if (rob[i].tag == tag && rob[i].ready) begin
                        rdy = 1'b1;
                        val = rob[i].value;
                    end
            end
        end
    endfunction

    always @(posedge clk_in) begin : p_model
        ent_t        hd;
        ent_t        ne;
        bit          do_commit;
        bit          flushing;
        int          sz;
        logic        er1, er2;
        logic [31:0] ev1, ev2;

        if (!rst_in) begin
            rob.delete();
            m_tail = '0; m_cv = 0; m_sc = 0; m_nf = 0;
            m_rd = '0; m_val = '0; m_fpc = '0; m_ctag = '0; m_stag = '0;
        end else if (!rdy_in) begin
            m_cv = 0; m_sc = 0; m_nf = 0;
        end else begin
            flushing  = m_nf;
            sz        = rob.size();
            m_cv = 0; m_sc = 0; m_nf = 0;
            do_commit = (sz > 0) && rob[0].ready;
            if (do_commit) hd = rob.pop_front();
            if (cdb_valid && !flushing)
                foreach (rob[i])
                    if (rob[i].tag == cdb_tag) begin
                        rob[i].ready = 1'b1;
                        rob[i].value = cdb_value;
                        rob[i].taken = cdb_taken;
                    end
            if (dec_valid && !flushing && sz < N) begin
                ne.tag    = m_tail;
                ne.kind   = (dec_type == 2'd3) ? 2'd0 : dec_type;
                ne.rd     = dec_rd;
                ne.value  = '0;
                ne.pred   = dec_pred_taken;
                ne.taken  = 1'b0;
                ne.pc_alt = dec_pc_alt;
                ne.ready  = (dec_type == 2'd1);
                rob.push_back(ne);
                m_tail = (m_tail == W'(N - 1)) ? '0 : m_tail + 1'b1;
            end
            if (do_commit) begin
                if (hd.kind == 2'd1) begin
                    m_sc   = 1'b1;
                    m_stag = hd.tag;
                end else begin
                    m_cv   = 1'b1;
                    m_rd   = hd.rd;
                    m_val  = hd.value;
                    m_ctag = hd.tag;
                    if (hd.kind == 2'd2 && hd.taken != hd.pred) begin
                        m_nf  = 1'b1;
                        m_fpc = hd.pc_alt;
                        rob.delete();
                        m_tail = '0;
                    end
                end
            end
        end

        #2;
        check("cyc_commit_valid", commit_valid_out, m_cv);
        check("cyc_commit_rd",    commit_rd_out,    m_rd);
        check("cyc_commit_value", commit_value_out, m_val);
        check("cyc_commit_tag",   commit_tag_out,   m_ctag);
        check("cyc_store_commit", store_commit_out, m_sc);
        check("cyc_store_tag",    store_tag_out,    m_stag);
        check("cyc_need_flush",   need_flush_out,   m_nf);
        check("cyc_flush_pc",     flush_pc_out,     m_fpc);
        check("cyc_full",         full_out,         (rob.size() == N));
        check("cyc_tail",         tail_out,         m_tail);
        mlook(q1_tag_in, er1, ev1);
        mlook(q2_tag_in, er2, ev2);
        check("cyc_q1_ready", q1_ready_out, er1);
        check("cyc_q1_value", q1_value_out, ev1);
        check("cyc_q2_ready", q2_ready_out, er2);
        check("cyc_q2_value", q2_value_out, ev2);
    end

    // ----------------------------------------------------------- stimulus
    task automatic tick();
        @(negedge clk_in);
    endtask

    initial begin
        repeat (2) tick();
        check("reset_commit_valid", commit_valid_out, 0);
        check("reset_tail", tail_out, 0);
        check("reset_full", full_out, 0);
        check("reset_flush", need_flush_out, 0);
        rst_in = 1'b1;

        // Basic issue -> writeback -> commit
        dec_valid = 1; dec_type = 2'd0; dec_rd = 5'd5; tick(); dec_valid = 0;
        check("t1_tail", tail_out, 1);
        cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h1234; tick(); cdb_valid = 0;
        check("t1_not_early", commit_valid_out, 0);
        tick();
        check("t1_commit_valid", commit_valid_out, 1);
        check("t1_commit_rd", commit_rd_out, 5);
        check("t1_commit_value", commit_value_out, 32'h1234);
        check("t1_commit_tag", commit_tag_out, 0);
        tick();
        check("t1_pulse_width", commit_valid_out, 0);

        // Asynchronous reset while a commit pulse is showing
        dec_valid = 1; dec_rd = 5'd12; tick(); dec_rd = 5'd13; tick(); dec_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd1; cdb_value = 32'h77; tick(); cdb_valid = 0;
        tick();
        check("rst_pre_commit", commit_valid_out, 1);
        rst_in = 1'b0;
        #1;
        check("rst_async_commit", commit_valid_out, 0);
        check("rst_async_rd", commit_rd_out, 0);
        check("rst_async_tail", tail_out, 0);
        tick();
        rst_in = 1'b1;
        cdb_valid = 1; cdb_tag = 3'd2; cdb_value = 32'h88; tick(); cdb_valid = 0;
        tick();
        check("rst_discarded", commit_valid_out, 0);

        // Fill to full, then an ignored 8th issue
        for (int i = 0; i < N; i++) begin
            dec_valid = 1; dec_type = 2'd0; dec_rd = RW'(i + 8); tick();
        end
        check("t2_full", full_out, 1);
        check("t2_tail_wrap", tail_out, 0);
        dec_rd = 5'd31; tick(); dec_valid = 0;
        check("t2_full_hold", full_out, 1);
        check("t2_tail_hold", tail_out, 0);

        // Out-of-order writeback, in-order retirement
        for (int t = N - 1; t >= 1; t--) begin
            cdb_valid = 1; cdb_tag = W'(t); cdb_value = 32'h100 + t; tick();
        end
        cdb_valid = 0;
        check("t3_younger_not_first", commit_valid_out, 0);
        cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h100; tick(); cdb_valid = 0;
        tick();
        check("t3_first_tag", commit_tag_out, 0);
        check("t3_first_rd", commit_rd_out, 8);
        check("t3_first_value", commit_value_out, 32'h100);
        tick();
        check("t3_second_valid", commit_valid_out, 1);
        check("t3_second_tag", commit_tag_out, 1);
        check("t3_second_value", commit_value_out, 32'h101);
        repeat (5) tick();
        check("t3_last_tag", commit_tag_out, 6);
        tick();
        check("t3_drained", commit_valid_out, 0);
        check("t3_not_full", full_out, 0);

        // Mispredicted branch with three younger entries
        dec_valid = 1; dec_type = 2'd2; dec_rd = 5'd1; dec_pred_taken = 0;
        dec_pc_alt = 32'h80; tick();
        dec_type = 2'd0; dec_pc_alt = '0;
        for (int i = 0; i < 3; i++) begin dec_rd = RW'(2 + i); tick(); end
        dec_valid = 0;
        for (int t = 1; t <= 3; t++) begin
            cdb_valid = 1; cdb_tag = W'(t); cdb_value = 32'h200 + t; tick();
        end
        cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h44; cdb_taken = 1; tick();
        cdb_valid = 0; cdb_taken = 0;
        check("t4_no_flush_yet", need_flush_out, 0);
        tick();
        check("t4_flush", need_flush_out, 1);
        check("t4_flush_pc", flush_pc_out, 32'h80);
        check("t4_branch_commit", commit_valid_out, 1);
        check("t4_branch_value", commit_value_out, 32'h44);
        check("t4_tail_zero", tail_out, 0);
        dec_valid = 1; dec_rd = 5'd9; cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h999;
        tick(); dec_valid = 0; cdb_valid = 0;
        check("t4_flush_one_cycle", need_flush_out, 0);
        check("t4_issue_ignored", tail_out, 0);
        repeat (3) begin
            tick();
            check("t4_younger_squashed", commit_valid_out, 0);
        end
        dec_valid = 1; dec_rd = 5'd7; tick(); dec_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 32'h700; tick(); cdb_valid = 0;
        tick();
        check("t4_resume_rd", commit_rd_out, 7);

        // Store at head held by a 3-cycle stall (issue attempts ignored)
        dec_valid = 1; dec_type = 2'd1; dec_rd = 5'd0; tick();
        dec_type = 2'd0; dec_rd = 5'd3; rdy_in = 0;
        repeat (3) begin
            tick();
            check("t5_stalled", store_commit_out, 0);
        end
        dec_valid = 0; rdy_in = 1;
        check("t5_tail_stalled", tail_out, 2);
        tick();
        check("t5_store_pulse", store_commit_out, 1);
        check("t5_store_tag", store_tag_out, 1);
        tick();
        check("t5_store_once", store_commit_out, 0);

        // Operand lookup: stored result and CDB bypass
        dec_valid = 1; dec_rd = 5'd10; tick(); dec_rd = 5'd11; tick(); dec_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 32'h55; tick();
        q1_tag_in = 3'd2; q2_tag_in = 3'd3;
        cdb_tag = 3'd2; cdb_value = 32'hBEEF;
        #1;
        check("t6_q1_ready", q1_ready_out, FWD);
        check("t6_q1_value", q1_value_out, FWD ? 32'hBEEF : 32'h0);
        check("t6_q2_ready", q2_ready_out, FWD);
        check("t6_q2_value", q2_value_out, FWD ? 32'h55 : 32'h0);
        tick();
        q1_tag_in = 3'd7; cdb_tag = 3'd7; cdb_value = 32'hDEAD;
        #1;
        check("t6_none_tag_miss", q1_ready_out, 0);
        tick(); cdb_valid = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
